// File: rtl/cmp_bist.sv
// Self-test engine for a 2-bit magnitude comparator: sweeps every A/B pair, checks F1/F2/F3
// against a golden model and reports the result. Optional macro: CMP_BIST_STOP_ON_FAIL_EN.
module cmp_bist #(
  parameter int WIDTH       = 2,
  parameter int HOLD_CYCLES = 4,
  parameter int ERR_W       = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  output logic [WIDTH-1:0] A,
  output logic [WIDTH-1:0] B,
  input  logic             F1,
  input  logic             F2,
  input  logic             F3,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_count,
  output logic [WIDTH-1:0] fail_a,
  output logic [WIDTH-1:0] fail_b,
  output logic [2:0]       fail_f
);

  localparam int IDX_W  = 2 * WIDTH;
  localparam int HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_APPLY = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  localparam logic [IDX_W-1:0]  IDX_ZERO  = {IDX_W{1'b0}};
  localparam logic [IDX_W-1:0]  IDX_ONE   = IDX_W'(1);
  localparam logic [IDX_W-1:0]  IDX_LAST  = {IDX_W{1'b1}};
  localparam logic [HOLD_W-1:0] HOLD_ZERO = {HOLD_W{1'b0}};
  localparam logic [HOLD_W-1:0] HOLD_ONE  = HOLD_W'(1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);
  localparam logic [ERR_W-1:0]  ERR_ZERO  = {ERR_W{1'b0}};
  localparam logic [ERR_W-1:0]  ERR_ONE   = ERR_W'(1);
  localparam logic [ERR_W-1:0]  ERR_MAX   = {ERR_W{1'b1}};
  localparam logic [WIDTH-1:0]  OPD_ZERO  = {WIDTH{1'b0}};

  function automatic logic [2:0] golden_f(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    golden_f = {a > b, a == b, a < b};
  endfunction

  logic [1:0]        state_r;
  logic [IDX_W-1:0]  idx_r;
  logic [HOLD_W-1:0] hold_r;

  logic              launch_s;
  logic              sample_s;
  logic              mismatch_s;
  logic              stop_s;
  logic [IDX_W-1:0]  next_idx_s;
  logic [ERR_W-1:0]  err_next_s;

  assign launch_s   = start && (state_r != ST_APPLY);
  assign sample_s   = (state_r == ST_APPLY) && (hold_r == HOLD_LAST);
  assign mismatch_s = sample_s && ({F1, F2, F3} != golden_f(A, B));
  assign next_idx_s = idx_r + IDX_ONE;

`ifdef CMP_BIST_STOP_ON_FAIL_EN
  assign stop_s = mismatch_s;
`else
  assign stop_s = 1'b0;
`endif

  // Saturating error count including the vector being sampled this cycle.
  always_comb begin
    err_next_s = err_count;
    if (mismatch_s && (err_count != ERR_MAX)) begin
      err_next_s = err_count + ERR_ONE;
    end else begin
      err_next_s = err_count;
    end
  end

  // Sweep sequencer, result capture and registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r   <= ST_IDLE;
      idx_r     <= IDX_ZERO;
      hold_r    <= HOLD_ZERO;
      A         <= OPD_ZERO;
      B         <= OPD_ZERO;
      busy      <= 1'b0;
      done      <= 1'b0;
      pass      <= 1'b0;
      err_count <= ERR_ZERO;
      fail_a    <= OPD_ZERO;
      fail_b    <= OPD_ZERO;
      fail_f    <= 3'b000;
    end else if (launch_s) begin
      state_r   <= ST_APPLY;
      idx_r     <= IDX_ZERO;
      hold_r    <= HOLD_ZERO;
      A         <= OPD_ZERO;
      B         <= OPD_ZERO;
      busy      <= 1'b1;
      done      <= 1'b0;
      pass      <= 1'b0;
      err_count <= ERR_ZERO;
      fail_a    <= OPD_ZERO;
      fail_b    <= OPD_ZERO;
      fail_f    <= 3'b000;
    end else begin
      case (state_r)
        ST_APPLY: begin
          hold_r <= hold_r + HOLD_ONE;
          if (sample_s) begin
            err_count <= err_next_s;
            // Only the first mismatch is captured; err_count is still zero then.
            if (mismatch_s && (err_count == ERR_ZERO)) begin
              fail_a <= A;
              fail_b <= B;
              fail_f <= {F1, F2, F3};
            end
            if ((idx_r == IDX_LAST) || stop_s) begin
              state_r <= ST_DONE;
              busy    <= 1'b0;
              done    <= 1'b1;
              pass    <= (err_next_s == ERR_ZERO);
            end else begin
              idx_r  <= next_idx_s;
              A      <= next_idx_s[IDX_W-1:WIDTH];
              B      <= next_idx_s[WIDTH-1:0];
              hold_r <= HOLD_ZERO;
            end
          end
        end
        ST_IDLE, ST_DONE: begin
          state_r <= state_r;
        end
        default: begin
          state_r <= ST_IDLE;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/cmp_bist.md
Name: cmp_bist

Overview:
- Synthesizable stimulus-and-check engine for the 2-bit magnitude comparator interface: A1 A0 B1 B0 in, F1 F2 F3 out.
- On start, sweeps all 2^(2*WIDTH) operand combinations into the comparator and holds each vector HOLD_CYCLES clocks.
- Samples F1/F2/F3 on the last hold cycle and checks them against a built-in golden model.
- Reports pass/fail, error count and the first failing vector; used as on-chip self-test beside the comparator.

Parameters:
- WIDTH, 2, operand width per side (A and B).
- HOLD_CYCLES, 4, clocks each vector is held before sampling (>=1).
- ERR_W, 8, width of the error counter.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  synchronous active-low reset.
- start  input  1  one-cycle request to run a sweep.
- A  output  WIDTH  operand A to comparator (A[1]=A1, A[0]=A0 at default).
- B  output  WIDTH  operand B to comparator (B[1]=B1, B[0]=B0).
- F1  input  1  comparator result, A>B.
- F2  input  1  comparator result, A==B.
- F3  input  1  comparator result, A<B.
- busy  output  1  sweep in progress.
- done  output  1  sweep finished; results valid.
- pass  output  1  done and zero errors.
- err_count  output  ERR_W  mismatching vectors, saturating.
- fail_a  output  WIDTH  A of first mismatch.
- fail_b  output  WIDTH  B of first mismatch.
- fail_f  output  3  observed {F1,F2,F3} at first mismatch.

Behaviour:
- Single clock domain. Reset is synchronous active-low on clk. All outputs are registered.
- Reset values: A=0, B=0, busy=0, done=0, pass=0, err_count=0, fail_a=0, fail_b=0, fail_f=0. State is IDLE.
- Vector index idx is 2*WIDTH bits wide. A=idx[2W-1:W], B=idx[W-1:0]. Order is 0..2^(2W)-1 with B0 as LSB, i.e. (A,B) = (0,0), (0,1), (0,2) ... (3,3).
- Golden model: expected {F1,F2,F3} = {A>B, A==B, A<B}, unsigned. A vector mismatches if any of the three bits differs.
- States:
  - IDLE: busy=0. When start=1: idx<=0, hold counter<=0, A/B<=vector 0, err_count<=0, fail_*<=0, done<=0, pass<=0, go to APPLY.
  - APPLY: busy=1. Hold counter increments each clock. On the cycle where hold==HOLD_CYCLES-1, compare F against the golden model for the current A/B.
    - On mismatch: err_count increments, saturating at 2^ERR_W-1. On the first mismatch only, fail_a/fail_b/fail_f capture.
    - If idx is the last index, go to DONE. Otherwise idx++, drive the new A/B, hold<=0.
  - DONE: busy=0, done=1, pass=(err_count==0). A/B hold the last vector. start=1 restarts exactly as from IDLE.
- Latency: start accepted at edge N gives done=1 at edge N + 2^(2W)*HOLD_CYCLES. At defaults that is 64 clocks.
- start while busy=1 is ignored.
- A error on the final vector is counted before done rises.
- rst_n=0 at any time, including mid-sweep, returns to IDLE with reset values at the next edge. rst_n has priority over start.
- HOLD_CYCLES=1: each vector is sampled in the same cycle it is first driven. This is legal only for purely combinational targets.

Optional Feature:
- Macro: CMP_BIST_STOP_ON_FAIL_EN.
- Defined: on the first mismatch, go directly to DONE after capture. err_count=1, pass=0, and A/B hold the failing vector.
- Undefined: the full sweep always completes and err_count totals all mismatches.

Test Plan:
- Correct comparator model, HOLD_CYCLES=4, start pulse -> busy for 64 clocks, then done=1, pass=1, err_count=0, fail_a=0, fail_b=0, fail_f=0.
- F2 stuck at 0 -> err_count=4 (the four equal vectors), pass=0, fail_a=0, fail_b=0, fail_f=3'b000.
- F1/F3 swapped -> err_count=12, first fail at fail_a=0, fail_b=1, fail_f=3'b100. With CMP_BIST_STOP_ON_FAIL_EN: done after vector idx=1 (8 clocks), err_count=1.
- Check A/B sequence -> A/B step through (0,0), (0,1) ... (3,3), each held exactly 4 clocks. start re-pulsed mid-sweep -> no effect on sequence or timing.
- rst_n=0 for one edge at clock 20 of a sweep -> next edge shows all outputs at reset values and IDLE. A new start -> full 64-clock sweep with correct result.
- From DONE with a faulty model, start again with a correct model -> err_count clears to 0 on acceptance, and the run ends pass=1.
